// File: rtl/br_param.sv
// Parametrised register bank with N combinational read ports, optional write
// bypass / hard-wired zero register, and a pending-write scoreboard.

module br_param_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              pend_bit,
    input  logic              wen,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);
    logic is_zero;
    logic fwd;

    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    // Forwarding is masked during reset so the port reads 0 while rst_n is low.
    assign fwd     = (BYPASS != 0) && rst_n && wen && (addr == wr_addr);

    always_comb begin
        rd_data = reg_val;
        busy    = pend_bit;
        if (is_zero) begin
            rd_data = '0;
            busy    = 1'b0;
        end else if (fwd) begin
            rd_data = wr_data;
            busy    = 1'b0;
        end
    end
endmodule

module br_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] direccion_lect,
    output logic [NUM_RD*DATA_W-1:0] datoLect,
    output logic [NUM_RD-1:0]        ocupado,
    input  logic                     Wen,
    input  logic [ADDR_W-1:0]        direccion_escritura,
    input  logic [DATA_W-1:0]        datoEscritura,
    input  logic                     emitir,
    input  logic [ADDR_W-1:0]        emitir_dir,
    input  logic                     vaciar,
    output logic [ADDR_W:0]          num_pend
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0]  regs;
    logic [DEPTH-1:0]              pend;
    logic [DEPTH-1:0]              pend_nxt;
    logic [ADDR_W:0]               cnt_nxt;
    logic                          wr_ok;
    logic                          iss_ok;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

    assign wr_ok  = Wen    && !((ZERO_REG != 0) && (direccion_escritura == '0));
    assign iss_ok = emitir && !((ZERO_REG != 0) && (emitir_dir == '0));

    // Issue applied after write-clear: a new producer supersedes the one retiring.
    always_comb begin
        pend_nxt = pend;
        if (vaciar) begin
            pend_nxt = '0;
        end else begin
            if (wr_ok)  pend_nxt[direccion_escritura] = 1'b0;
            if (iss_ok) pend_nxt[emitir_dir]          = 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt += {{ADDR_W{1'b0}}, pend_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs     <= '0;
            pend     <= '0;
            num_pend <= '0;
        end else begin
            if (wr_ok) regs[direccion_escritura] <= datoEscritura;
            pend     <= pend_nxt;
            num_pend <= cnt_nxt;
        end
    end

    assign rd_addr  = direccion_lect;
    assign datoLect = rd_data;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        br_param_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd (
            .rst_n   (rst_n),
            .addr    (rd_addr[k]),
            .reg_val (regs[rd_addr[k]]),
            .pend_bit(pend[rd_addr[k]]),
            .wen     (Wen),
            .wr_addr (direccion_escritura),
            .wr_data (datoEscritura),
            .rd_data (rd_data[k]),
            .busy    (ocupado[k])
        );
    end
endmodule

// File: tb/tb_br_param.sv
// Directed bench for br_param: one bypassing instance and one non-bypassing
// instance driven by the same stimulus.

module tb_br_param;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR*AW-1:0]   direccion_lect;
    logic [NR*DW-1:0]   rd_b, rd_n;
    logic [NR-1:0]      oc_b, oc_n;
    logic               Wen;
    logic [AW-1:0]      direccion_escritura;
    logic [DW-1:0]      datoEscritura;
    logic               emitir;
    logic [AW-1:0]      emitir_dir;
    logic               vaciar;
    logic [AW:0]        np_b, np_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    br_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .direccion_lect(direccion_lect), .datoLect(rd_b),
        .ocupado(oc_b), .Wen(Wen), .direccion_escritura(direccion_escritura),
        .datoEscritura(datoEscritura), .emitir(emitir), .emitir_dir(emitir_dir),
        .vaciar(vaciar), .num_pend(np_b)
    );

    br_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .direccion_lect(direccion_lect), .datoLect(rd_n),
        .ocupado(oc_n), .Wen(Wen), .direccion_escritura(direccion_escritura),
        .datoEscritura(datoEscritura), .emitir(emitir), .emitir_dir(emitir_dir),
        .vaciar(vaciar), .num_pend(np_n)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a0, input int a1);
        direccion_lect = {AW'(a1), AW'(a0)};
    endtask

    task automatic idle;
        Wen = 1'b0; emitir = 1'b0; vaciar = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; idle();
        direccion_escritura = '0; datoEscritura = '0; emitir_dir = '0;
        rd(0, 0);
        #12;
        chk("init_np", 64'(np_b), 64'd0);
        chk("init_rd", 64'(rd_b), 64'd0);
        #3 rst_n = 1'b1;
        step();

        // Reset: write r5, issue r8, then async reset mid-cycle
        Wen = 1'b1; direccion_escritura = 5'd5; datoEscritura = 32'hDEADBEEF;
        emitir = 1'b1; emitir_dir = 5'd8;
        step(); idle();
        rd(5, 8); #1;
        chk("pre_rst_r5", 64'(rd_b[31:0]), 64'hDEADBEEF);
        chk("pre_rst_oc8", 64'(oc_b[1]), 64'd1);
        chk("pre_rst_np", 64'(np_b), 64'd1);
        #1 rst_n = 1'b0; #1;
        chk("rst_r5", 64'(rd_b[31:0]), 64'd0);
        chk("rst_np", 64'(np_b), 64'd0);
        chk("rst_oc", 64'(oc_b), 64'd0);
        #1 rst_n = 1'b1;
        step();

        // Zero register
        Wen = 1'b1; direccion_escritura = 5'd0; datoEscritura = 32'h12345678;
        emitir = 1'b1; emitir_dir = 5'd0;
        rd(0, 0); #1;
        chk("zero_byp", 64'(rd_b[31:0]), 64'd0);
        chk("zero_oc", 64'(oc_b[0]), 64'd0);
        step(); idle(); #1;
        chk("zero_rd", 64'(rd_b[31:0]), 64'd0);
        chk("zero_np", 64'(np_b), 64'd0);
        chk("zero_oc2", 64'(oc_b[0]), 64'd0);

        // Bypass vs no bypass on port1
        Wen = 1'b1; direccion_escritura = 5'd7; datoEscritura = 32'hA5A5A5A5;
        rd(0, 7); #1;
        chk("byp_same", 64'(rd_b[63:32]), 64'hA5A5A5A5);
        chk("nobyp_same", 64'(rd_n[63:32]), 64'd0);
        step(); idle(); #1;
        chk("nobyp_after", 64'(rd_n[63:32]), 64'hA5A5A5A5);
        chk("byp_after", 64'(rd_b[63:32]), 64'hA5A5A5A5);

        // Scoreboard issue then retire
        emitir = 1'b1; emitir_dir = 5'd3;
        step(); idle();
        rd(3, 0); #1;
        chk("sb_oc", 64'(oc_b[0]), 64'd1);
        chk("sb_np", 64'(np_b), 64'd1);
        Wen = 1'b1; direccion_escritura = 5'd3; datoEscritura = 32'h55; #1;
        chk("sb_wr_oc", 64'(oc_b[0]), 64'd0);
        chk("sb_wr_rd", 64'(rd_b[31:0]), 64'h55);
        chk("sb_wr_oc_nb", 64'(oc_n[0]), 64'd1);
        step(); idle(); #1;
        chk("sb_np0", 64'(np_b), 64'd0);
        chk("sb_oc0", 64'(oc_b[0]), 64'd0);

        // Same-cycle issue and write on r9
        emitir = 1'b1; emitir_dir = 5'd9;
        step();
        Wen = 1'b1; direccion_escritura = 5'd9; datoEscritura = 32'h11;
        step(); idle();
        rd(9, 9); #1;
        chk("sim_rd", 64'(rd_b[31:0]), 64'h11);
        chk("sim_oc", 64'(oc_b), 64'd3);
        chk("sim_np", 64'(np_b), 64'd1);

        // Flush
        vaciar = 1'b1; step(); idle(); #1;
        chk("fl_pre_np", 64'(np_b), 64'd0);
        emitir = 1'b1;
        emitir_dir = 5'd1; step();
        emitir_dir = 5'd2; step();
        emitir_dir = 5'd4; step(); #1;
        chk("fl_np3", 64'(np_b), 64'd3);
        vaciar = 1'b1; emitir = 1'b1; emitir_dir = 5'd6;
        Wen = 1'b1; direccion_escritura = 5'd2; datoEscritura = 32'h22;
        step(); idle();
        rd(6, 2); #1;
        chk("fl_np", 64'(np_b), 64'd0);
        chk("fl_oc", 64'(oc_b), 64'd0);
        chk("fl_r2", 64'(rd_b[63:32]), 64'h22);
        chk("fl_np_nb", 64'(np_n), 64'd0);

        // Shared address on both ports
        rd(2, 2); #1;
        chk("share_rd", 64'(rd_b), {32'h22, 32'h22});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
